// File: rtl/bcd_mult_arbiter_if.sv
// Request/response/multiplier bundle for bcd_mult_arbiter.
// The master side is the requester pair, the response consumer and the shared multiplier.
interface bcd_mult_arbiter_if;
   logic [1:0]  req_valid;
   logic [31:0] req_x;
   logic [31:0] req_y;
   logic [1:0]  req_ready;
   logic        rsp_valid;
   logic        rsp_id;
   logic [31:0] rsp_product;
   logic        rsp_err;
   logic        rsp_ready;
   logic [15:0] mul_x;
   logic [15:0] mul_y;
   logic [31:0] mul_product;

   modport master (
      output req_valid, req_x, req_y, rsp_ready, mul_product,
      input  req_ready, rsp_valid, rsp_id, rsp_product, rsp_err, mul_x, mul_y
   );

   modport slave (
      input  req_valid, req_x, req_y, rsp_ready, mul_product,
      output req_ready, rsp_valid, rsp_id, rsp_product, rsp_err, mul_x, mul_y
   );
endinterface

// File: rtl/bcd_mult_arbiter.sv
// Round-robin arbiter letting two requesters share one combinational BCD multiplier.
// Operands are digit-checked at grant; the product is sampled after a fixed settle window.
module bcd_mult_arbiter #(
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   bcd_mult_arbiter_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

   state_t      state;
   logic [3:0]  cnt;
   logic        ptr;      // requester favoured when both are valid
   logic [1:0]  grant;
   logic        gnt_id;
   logic [15:0] sel_x;
   logic [15:0] sel_y;
   logic        bad_bcd;

   function automatic logic has_bad_digit(input logic [15:0] v);
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (v[4*i +: 4] > 4'd9) bad = 1'b1;
      end
      return bad;
   endfunction

   // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      grant  = 2'b00;
      gnt_id = (bus.req_valid == 2'b11) ? ptr : bus.req_valid[1];
      if (state == IDLE && !rst && bus.req_valid != 2'b00) begin
         grant = gnt_id ? 2'b10 : 2'b01;
      end
      sel_x   = gnt_id ? bus.req_x[31:16] : bus.req_x[15:0];
      sel_y   = gnt_id ? bus.req_y[31:16] : bus.req_y[15:0];
      bad_bcd = has_bad_digit(sel_x) | has_bad_digit(sel_y);
   end

   assign bus.req_ready = grant;

   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         cnt             <= 4'd0;
         ptr             <= 1'b0;
         bus.rsp_valid   <= 1'b0;
         bus.rsp_id      <= 1'b0;
         bus.rsp_product <= 32'd0;
         bus.rsp_err     <= 1'b0;
         bus.mul_x       <= 16'd0;
         bus.mul_y       <= 16'd0;
      end else begin
         unique case (state)
            IDLE: begin
               if (grant != 2'b00) begin
                  bus.mul_x  <= sel_x;
                  bus.mul_y  <= sel_y;
                  bus.rsp_id <= gnt_id;
                  ptr        <= ~gnt_id;
                  if (bad_bcd) begin
                     // Bad digits never reach the multiplier result path.
                     state           <= RESP;
                     bus.rsp_valid   <= 1'b1;
                     bus.rsp_err     <= 1'b1;
                     bus.rsp_product <= 32'd0;
                     cnt             <= 4'd0;
                  end else begin
                     state <= SETTLE;
                     cnt   <= SETTLE_LOAD;
                  end
               end
            end
            SETTLE: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) begin
                  state           <= RESP;
                  bus.rsp_valid   <= 1'b1;
                  bus.rsp_err     <= 1'b0;
                  bus.rsp_product <= bus.mul_product;
               end
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  state         <= IDLE;
                  bus.rsp_valid <= 1'b0;
               end
            end
            default: begin
               state         <= IDLE;
               bus.rsp_valid <= 1'b0;
            end
         endcase
      end
   end
endmodule
